sram_req_arbiter: RTL
=====================

Name: sram_req_arbiter

Overview:
- Shares one downstream sram-like port (into the AXI bridge) between the inst requester (port 0) and the data requester (port 1).
- Grants one request per cycle, using fixed data-over-inst priority or optional round-robin.
- Holds the grant until the downstream port accepts the request.
- Records every accepted transaction in an in-order outstanding FIFO, routes each data_ok/rdata back to its owner, and stalls reads that hit an outstanding write (read-after-write protection).

Parameters:
- OT_DEPTH, 4, outstanding FIFO depth; power of 2, minimum 2.
- PTR_W, $clog2(OT_DEPTH), FIFO pointer width; derived, do not override.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset
- inst_req, inst_wr  in  1  inst requester request / write flag
- inst_size  in  2  inst request size
- inst_wstrb  in  4  inst write strobe
- inst_addr, inst_wdata  in  32  inst address / write data
- inst_addr_ok, inst_data_ok  out  1  inst request accepted / response done
- inst_rdata  out  32  inst read data
- data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata, data_addr_ok, data_data_ok, data_rdata: same directions and widths as the inst_* ports, for the data requester
- m_req, m_wr  out  1  downstream request / write flag
- m_size  out  2  downstream size
- m_wstrb  out  4  downstream write strobe
- m_addr, m_wdata  out  32  downstream address / write data
- m_addr_ok, m_data_ok  in  1  downstream accept / response
- m_rdata  in  32  downstream read data
- ot_count  out  PTR_W+1  number of outstanding transactions
- err_unexpected  out  1  sticky: data_ok arrived with the FIFO empty

Behaviour:
- Reset: aresetn is synchronous, active-low; clock is aclk.
  - On reset: state IDLE, FIFO empty, ot_count=0, err_unexpected=0, round-robin pointer selects inst.
  - Combinational outputs m_req, *_addr_ok and *_data_ok read 0 while aresetn=0.
- Grant FSM states: IDLE, LOCK_INST, LOCK_DATA.
  - IDLE: choose the winner among eligible requesters (data wins by default).
  - IDLE, winner present and m_addr_ok=1: stay in IDLE.
  - IDLE, winner present and m_addr_ok=0: go to LOCK_<winner>.
  - LOCK_x: requester x is driven downstream regardless of the other requester; return to IDLE on m_addr_ok.
  - LOCK_x with x_req dropped (protocol violation): return to IDLE, push nothing.
- Eligibility: req=1, FIFO not full, and no RAW hazard.
  - RAW hazard = a read (wr=0) whose addr[31:2] matches addr[31:2] of any valid FIFO entry with wr=1.
  - A requester already in LOCK_x is not re-checked.
- Downstream mux: m_* = winner's fields, zero-latency pass-through; m_req=0 when there is no winner.
- Handshake:
  - x_addr_ok = m_addr_ok & m_req & (winner==x).
  - When that handshake completes, push {owner, wr, addr[31:2]} into the FIFO.
- Responses: downstream returns data_ok in acceptance order.
  - On m_data_ok, pop the head entry.
  - Assert owner_data_ok for 1 cycle, same cycle as m_data_ok (combinational).
  - owner_rdata = m_rdata; the other requester's rdata holds its last value (registered copy).
- Full FIFO: no grant, m_req=0.
  - A push in the same cycle as a pop while full is still blocked; this keeps the logic deterministic.
  - Push and pop in the same cycle when not full: ot_count unchanged.
- Empty FIFO with m_data_ok: response ignored, no data_ok to either requester, err_unexpected set until reset.
- Same-cycle pop of a matching write clears the hazard only from the next cycle.
- ot_count = push count minus pop count; never exceeds OT_DEPTH.
- Pointers wrap modulo OT_DEPTH.
- Reset mid-operation clears FIFO and FSM; responses arriving afterwards are treated as unexpected.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: in IDLE with both requesters eligible, the requester not granted last wins; the pointer updates on each completed addr handshake.
- Undefined: fixed priority, data always beats inst; the pointer logic is absent.

Test Plan:
- Both request reads in the same cycle (inst addr 0x1C000000, data addr 0x00001000), m_addr_ok=1 → data_addr_ok first; inst_addr_ok next cycle (without RR); ot_count goes 1 then 2.
- inst read at 0x1C000004 with m_addr_ok held low 3 cycles, data_req rising during the stall → m_addr stays 0x1C000004 (LOCK_INST) until accepted; data is granted afterwards.
- data write to 0x00002008 outstanding, then data read of 0x0000200C (same word after [31:2]? no) vs 0x0000200A → the 0x0000200A read stalls (m_req=0) until the write's m_data_ok; the 0x0000200C read proceeds immediately.
- OT_DEPTH=4: accept 4 inst reads without m_data_ok → 5th request sees m_req=0, ot_count=4; one m_data_ok → 5th granted the following cycle.
- Interleaved inst/data/inst accepted, three m_data_ok with rdata 0xA, 0xB, 0xC → inst_data_ok with 0xA, data_data_ok with 0xB, inst_data_ok with 0xC.
- m_data_ok pulse with FIFO empty → no *_data_ok; err_unexpected=1 and stays set until aresetn=0.

Source files
------------

// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter: shares one sram-like downstream port between the inst
// requester (port 0) and the data requester (port 1). It tracks accepted
// transactions in an in-order outstanding FIFO, routes each response back to
// its owner, and stalls reads that hit an outstanding write.
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin arbitration.
// The default build uses fixed data-over-inst priority.
module sram_req_arbiter #(
  parameter int unsigned OT_DEPTH = 4,
  parameter int unsigned PTR_W    = $clog2(OT_DEPTH)
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             inst_req,
  input  logic             inst_wr,
  input  logic [1:0]       inst_size,
  input  logic [3:0]       inst_wstrb,
  input  logic [31:0]      inst_addr,
  input  logic [31:0]      inst_wdata,
  output logic             inst_addr_ok,
  output logic             inst_data_ok,
  output logic [31:0]      inst_rdata,
  input  logic             data_req,
  input  logic             data_wr,
  input  logic [1:0]       data_size,
  input  logic [3:0]       data_wstrb,
  input  logic [31:0]      data_addr,
  input  logic [31:0]      data_wdata,
  output logic             data_addr_ok,
  output logic             data_data_ok,
  output logic [31:0]      data_rdata,
  output logic             m_req,
  output logic             m_wr,
  output logic [1:0]       m_size,
  output logic [3:0]       m_wstrb,
  output logic [31:0]      m_addr,
  output logic [31:0]      m_wdata,
  input  logic             m_addr_ok,
  input  logic             m_data_ok,
  input  logic [31:0]      m_rdata,
  output logic [PTR_W:0]   ot_count,
  output logic             err_unexpected
);

  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned WORD_W = 30;

  typedef enum logic [1:0] {IDLE, LOCK_INST, LOCK_DATA} state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                err_q, err_d;
  logic [31:0]         inst_rdata_q, inst_rdata_d;
  logic [31:0]         data_rdata_q, data_rdata_d;
  logic [OT_DEPTH-1:0] fifo_owner_q, fifo_owner_d;
  logic [OT_DEPTH-1:0] fifo_wr_q, fifo_wr_d;
  logic [WORD_W-1:0]   fifo_word_q [OT_DEPTH];
  logic [WORD_W-1:0]   fifo_word_d [OT_DEPTH];
`ifdef ARB_ROUND_ROBIN_EN
  logic                rr_data_q, rr_data_d;
`endif

  logic [OT_DEPTH-1:0] ent_valid;
  logic                full, empty;
  logic                inst_hit, data_hit;
  logic                inst_elig, data_elig;
  logic                win_inst, win_data;
  logic                hs, push, pop, unexpected, head_owner;

  assign full       = (count_q == CNT_W'(OT_DEPTH));
  assign empty      = (count_q == '0);
  assign head_owner = fifo_owner_q[rd_ptr_q];

  // Mark FIFO slots that currently hold an outstanding transaction
  always_comb begin
    logic [PTR_W-1:0] off;
    off       = '0;
    ent_valid = '0;
    for (int i = 0; i < OT_DEPTH; i++) begin
      off          = PTR_W'(i) - rd_ptr_q;
      ent_valid[i] = ({1'b0, off} < count_q);
    end
  end

  // Read-after-write hazard: the requested word matches an outstanding write
  always_comb begin
    inst_hit = 1'b0;
    data_hit = 1'b0;
    for (int i = 0; i < OT_DEPTH; i++) begin
      if (ent_valid[i] && fifo_wr_q[i]) begin
        if (fifo_word_q[i] == inst_addr[31:2]) inst_hit = 1'b1;
        if (fifo_word_q[i] == data_addr[31:2]) data_hit = 1'b1;
      end
    end
  end

  assign inst_elig = inst_req & ~full & ~(~inst_wr & inst_hit);
  assign data_elig = data_req & ~full & ~(~data_wr & data_hit);

  // Grant FSM next state and winner selection
  always_comb begin
    state_d  = state_q;
    win_inst = 1'b0;
    win_data = 1'b0;
    unique case (state_q)
      IDLE: begin
`ifdef ARB_ROUND_ROBIN_EN
        if (inst_elig && data_elig) begin
          win_data = rr_data_q;
          win_inst = ~rr_data_q;
        end else begin
          win_data = data_elig;
          win_inst = inst_elig;
        end
`else
        win_data = data_elig;
        win_inst = inst_elig & ~data_elig;
`endif
        if (win_data && !m_addr_ok)      state_d = LOCK_DATA;
        else if (win_inst && !m_addr_ok) state_d = LOCK_INST;
      end
      LOCK_INST: begin
        if (!inst_req) begin
          state_d = IDLE;
        end else begin
          win_inst = 1'b1;
          if (m_addr_ok) state_d = IDLE;
        end
      end
      LOCK_DATA: begin
        if (!data_req) begin
          state_d = IDLE;
        end else begin
          win_data = 1'b1;
          if (m_addr_ok) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!aresetn) begin
      win_inst = 1'b0;
      win_data = 1'b0;
    end
  end

  // Downstream mux: zero-latency pass-through of the winner's fields
  assign m_req   = win_inst | win_data;
  assign m_wr    = win_data ? data_wr    : (win_inst ? inst_wr    : 1'b0);
  assign m_size  = win_data ? data_size  : (win_inst ? inst_size  : '0);
  assign m_wstrb = win_data ? data_wstrb : (win_inst ? inst_wstrb : '0);
  assign m_addr  = win_data ? data_addr  : (win_inst ? inst_addr  : '0);
  assign m_wdata = win_data ? data_wdata : (win_inst ? inst_wdata : '0);

  assign hs           = m_req & m_addr_ok;
  assign push         = hs;
  assign inst_addr_ok = hs & win_inst;
  assign data_addr_ok = hs & win_data;

  assign pop          = aresetn & m_data_ok & ~empty;
  assign unexpected   = aresetn & m_data_ok & empty;
  assign inst_data_ok = pop & ~head_owner;
  assign data_data_ok = pop & head_owner;
  assign inst_rdata   = inst_data_ok ? m_rdata : inst_rdata_q;
  assign data_rdata   = data_data_ok ? m_rdata : data_rdata_q;

  assign ot_count       = count_q;
  assign err_unexpected = err_q;

  // FIFO push/pop, counters, sticky error and held read data
  always_comb begin
    fifo_owner_d = fifo_owner_q;
    fifo_wr_d    = fifo_wr_q;
    fifo_word_d  = fifo_word_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    if (push) begin
      fifo_owner_d[wr_ptr_q] = win_data;
      fifo_wr_d[wr_ptr_q]    = m_wr;
      fifo_word_d[wr_ptr_q]  = m_addr[31:2];
      wr_ptr_d               = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d      = count_q + CNT_W'(push) - CNT_W'(pop);
    err_d        = err_q | unexpected;
    inst_rdata_d = inst_rdata;
    data_rdata_d = data_rdata;
  end

`ifdef ARB_ROUND_ROBIN_EN
  // After a completed handshake the other requester gets preference
  always_comb begin
    rr_data_d = rr_data_q;
    if (hs) rr_data_d = win_inst;
  end
`endif

  // Control state with synchronous active-low reset
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      err_q        <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_data_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      err_q        <= err_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
      rr_data_q    <= rr_data_d;
`endif
    end
  end

  // FIFO payload storage; validity comes from the pointers and count
  always_ff @(posedge aclk) begin
    fifo_owner_q <= fifo_owner_d;
    fifo_wr_q    <= fifo_wr_d;
    fifo_word_q  <= fifo_word_d;
  end

endmodule
